// File: rtl/umem_responder.sv
// Word read/write responder over a byte-organised memory it owns.
// Accepts one request at a time and answers after WAIT_STATES extra cycles.
module umem_responder #(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW  = $clog2(MEM_BYTES);
  localparam int unsigned WordW = IdxW - 2;
  localparam logic [ADDR_W:0] LastByteOfs = {{(ADDR_W - 1){1'b0}}, 2'b11};

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        mem_q [MEM_BYTES];
  logic [7:0]        mem_d [MEM_BYTES];

  logic [ADDR_W:0]   addr_end;
  logic              access_err;
  logic [WordW-1:0]  word_idx;
  logic [31:0]       rd_word;

  // One extra address bit keeps addr+3 from wrapping back into range.
  always_comb begin
    addr_end   = {1'b0, addr_q} + LastByteOfs;
    access_err = (addr_q[1:0] != 2'b00) || (32'(addr_end) >= MEM_BYTES);
    word_idx   = addr_q[IdxW-1:2];
    rd_word    = {mem_q[{word_idx, 2'd3}], mem_q[{word_idx, 2'd2}],
                  mem_q[{word_idx, 2'd1}], mem_q[{word_idx, 2'd0}]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_d       = mem_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = req_be;
          cnt_d       = 4'(WAIT_STATES);
          req_ready_d = 1'b0;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = access_err;
          rsp_rdata_d = '0;
          state_d     = StResp;
          if (!access_err) begin
            if (write_q) begin
              for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_d[{word_idx, 2'(i)}] = wdata_q[8*i +: 8];
              end
            end else begin
              rsp_rdata_d = rd_word;
            end
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < int'(MEM_BYTES); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_q       <= mem_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
